// File: rtl/iigs_sd_pkg.sv
// Shared definitions for the SD block-request arbiter: arbiter FSM states,
// default drive count and LBA/timer widths.
package iigs_sd_pkg;

    localparam int unsigned NUM_DRV_DEF = 3;
    localparam int unsigned LBA_W       = 32;
    localparam int unsigned TIMER_W     = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_FIN
    } arb_state_t;

endpackage

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting slot at or
// after last+1 (mod N) as a one-hot grant, plus a valid flag.
module rr_pick
    import iigs_sd_pkg::*;
#(
    parameter int unsigned N     = NUM_DRV_DEF,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IDX_W'((32'(last) + k) % N);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Arbitrates per-drive sector read/write requests onto the shared SD block
// interface, one drive at a time in round-robin order, with mount tracking.
module sd_req_arbiter
    import iigs_sd_pkg::*;
#(
    parameter int unsigned          NUM_DRV = NUM_DRV_DEF,
    parameter logic [TIMER_W-1:0]   TIMEOUT = 24'd8_000_000
) (
    input  logic                       clk_sys,
    input  logic                       reset,

    input  logic [NUM_DRV-1:0]         drv_rd,
    input  logic [NUM_DRV-1:0]         drv_wr,
    input  logic [NUM_DRV*LBA_W-1:0]   drv_lba,
    output logic [NUM_DRV-1:0]         drv_busy,
    output logic [NUM_DRV-1:0]         drv_done,
    output logic [NUM_DRV-1:0]         drv_err,
    output logic [NUM_DRV-1:0]         drv_mounted,
    output logic [NUM_DRV-1:0]         drv_protect,
    output logic [NUM_DRV-1:0]         drv_buff_we,
    output logic                       cpu_wait,

    output logic [NUM_DRV*LBA_W-1:0]   sd_lba,
    output logic [NUM_DRV-1:0]         sd_rd,
    output logic [NUM_DRV-1:0]         sd_wr,
    input  logic [NUM_DRV-1:0]         sd_ack,
    input  logic                       sd_buff_wr,

    input  logic [NUM_DRV-1:0]         img_mounted,
    input  logic                       img_readonly,
    input  logic [63:0]                img_size
);

    localparam int unsigned IDX_W = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1;

    arb_state_t                 state_q, state_d;
    logic [IDX_W-1:0]           grant_q, grant_d;
    logic [IDX_W-1:0]           last_grant_q, last_grant_d;
    logic [TIMER_W-1:0]         timer_q, timer_d;
    logic [NUM_DRV-1:0]         busy_q, busy_d;
    logic [NUM_DRV-1:0]         op_wr_q, op_wr_d;
    logic [NUM_DRV*LBA_W-1:0]   lba_lat_q, lba_lat_d;
    logic [NUM_DRV*LBA_W-1:0]   sd_lba_q, sd_lba_d;
    logic [NUM_DRV-1:0]         sd_rd_q, sd_rd_d;
    logic [NUM_DRV-1:0]         sd_wr_q, sd_wr_d;
    logic [NUM_DRV-1:0]         done_q, done_d;
    logic [NUM_DRV-1:0]         err_q, err_d;
    logic [NUM_DRV-1:0]         ack_s_q, ack_s_d;
    logic [NUM_DRV-1:0]         ack_old_q, ack_old_d;
    logic [NUM_DRV-1:0]         mounted_q, mounted_d;
    logic [NUM_DRV-1:0]         protect_q, protect_d;

    logic [NUM_DRV-1:0]         pick_gnt;
    logic                       pick_valid;
    logic [IDX_W-1:0]           pick_idx;

    rr_pick #(
        .N     (NUM_DRV),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (busy_q),
        .last  (last_grant_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_DRV; i++) begin
            if (pick_gnt[i]) pick_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        busy_d       = busy_q;
        op_wr_d      = op_wr_q;
        lba_lat_d    = lba_lat_q;
        sd_lba_d     = sd_lba_q;
        sd_rd_d      = sd_rd_q;
        sd_wr_d      = sd_wr_q;
        done_d       = '0;
        err_d        = '0;
        ack_s_d      = sd_ack;
        ack_old_d    = ack_s_q;
        mounted_d    = mounted_q;
        protect_d    = protect_q;

        for (int unsigned i = 0; i < NUM_DRV; i++) begin
            if (img_mounted[i]) begin
                mounted_d[i] = |img_size;
                protect_d[i] = img_readonly;
            end
        end

        // A slot that is already busy can never be the one the FSM clears
        // below, so acceptance and FSM updates never touch the same bit.
        for (int unsigned i = 0; i < NUM_DRV; i++) begin
            if ((drv_rd[i] || drv_wr[i]) && !busy_q[i]) begin
                if (!mounted_q[i] || (drv_wr[i] && protect_q[i])) begin
                    err_d[i] = 1'b1;
                end else begin
                    busy_d[i]                   = 1'b1;
                    op_wr_d[i]                  = drv_wr[i];
                    lba_lat_d[i*LBA_W +: LBA_W] = drv_lba[i*LBA_W +: LBA_W];
                end
            end
        end

        case (state_q)
            // FIN's done/busy/last_grant updates are registered on entry, so
            // FIN arbitrates like IDLE and the next grant is not delayed.
            ST_IDLE, ST_FIN: begin
                state_d = ST_IDLE;
                if (pick_valid) begin
                    grant_d                            = pick_idx;
                    sd_rd_d[pick_idx]                  = ~op_wr_q[pick_idx];
                    sd_wr_d[pick_idx]                  = op_wr_q[pick_idx];
                    sd_lba_d[pick_idx*LBA_W +: LBA_W]  = lba_lat_q[pick_idx*LBA_W +: LBA_W];
                    timer_d                            = '0;
                    state_d                            = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s_q[grant_q] && !ack_old_q[grant_q]) begin
                    sd_rd_d[grant_q] = 1'b0;
                    sd_wr_d[grant_q] = 1'b0;
                    state_d          = ST_XFER;
                end else if (timer_q == TIMEOUT - TIMER_W'(1)) begin
                    sd_rd_d[grant_q] = 1'b0;
                    sd_wr_d[grant_q] = 1'b0;
                    busy_d[grant_q]  = 1'b0;
                    err_d[grant_q]   = 1'b1;
                    state_d          = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_XFER: begin
                if (!ack_s_q[grant_q] && ack_old_q[grant_q]) begin
                    busy_d[grant_q] = 1'b0;
                    done_d[grant_q] = 1'b1;
                    last_grant_d    = grant_q;
                    state_d         = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_DRV - 1);
            timer_q      <= '0;
            busy_q       <= '0;
            op_wr_q      <= '0;
            lba_lat_q    <= '0;
            sd_lba_q     <= '0;
            sd_rd_q      <= '0;
            sd_wr_q      <= '0;
            done_q       <= '0;
            err_q        <= '0;
            ack_s_q      <= '0;
            ack_old_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            busy_q       <= busy_d;
            op_wr_q      <= op_wr_d;
            lba_lat_q    <= lba_lat_d;
            sd_lba_q     <= sd_lba_d;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
            done_q       <= done_d;
            err_q        <= err_d;
            ack_s_q      <= ack_s_d;
            ack_old_q    <= ack_old_d;
        end
    end

    // Mount status survives reset; it only starts from zero at power-up.
    always_ff @(posedge clk_sys) begin
        mounted_q <= mounted_d;
        protect_q <= protect_d;
    end

    assign drv_busy    = busy_q;
    assign drv_done    = done_q;
    assign drv_err     = err_q;
    assign drv_mounted = mounted_q;
    assign drv_protect = protect_q;
    assign drv_buff_we = {NUM_DRV{sd_buff_wr}} & sd_ack;
    assign cpu_wait    = |busy_q;
    assign sd_lba      = sd_lba_q;
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter: mount, reject, round-robin, timeout and
// reset scenarios with hand-computed expected values.
module tb_sd_req_arbiter;

    logic         clk_sys;
    logic         reset;
    logic [2:0]   drv_rd;
    logic [2:0]   drv_wr;
    logic [95:0]  drv_lba;
    logic [2:0]   drv_busy;
    logic [2:0]   drv_done;
    logic [2:0]   drv_err;
    logic [2:0]   drv_mounted;
    logic [2:0]   drv_protect;
    logic [2:0]   drv_buff_we;
    logic         cpu_wait;
    logic [95:0]  sd_lba;
    logic [2:0]   sd_rd;
    logic [2:0]   sd_wr;
    logic [2:0]   sd_ack;
    logic         sd_buff_wr;
    logic [2:0]   img_mounted;
    logic         img_readonly;
    logic [63:0]  img_size;

    int checks = 0;
    int errors = 0;

    sd_req_arbiter #(
        .NUM_DRV (3),
        .TIMEOUT (24'd100)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_lba      (drv_lba),
        .drv_busy     (drv_busy),
        .drv_done     (drv_done),
        .drv_err      (drv_err),
        .drv_mounted  (drv_mounted),
        .drv_protect  (drv_protect),
        .drv_buff_we  (drv_buff_we),
        .cpu_wait     (cpu_wait),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size     (img_size)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic cyc();
        @(negedge clk_sys);
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        drv_rd       = '0;
        drv_wr       = '0;
        drv_lba      = '0;
        sd_ack       = '0;
        sd_buff_wr   = 1'b0;
        img_mounted  = '0;
        img_readonly = 1'b0;
        img_size     = '0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_busy", 96'(drv_busy), 96'h0);
        chk("rst_sd_rd", 96'(sd_rd), 96'h0);
        chk("rst_sd_wr", 96'(sd_wr), 96'h0);
        chk("rst_sd_lba", sd_lba, 96'h0);
        chk("rst_done_err", 96'({drv_done, drv_err}), 96'h0);
        chk("rst_cpu_wait", 96'(cpu_wait), 96'h0);

        // Mount 0 and 1 read/write (800K), 2 with size zero
        img_size = 64'd819200; img_readonly = 1'b0;
        img_mounted = 3'b001; cyc();
        img_mounted = 3'b010; cyc();
        img_size = 64'd0;
        img_mounted = 3'b100; cyc();
        img_mounted = 3'b000;
        chk("mount_state", 96'(drv_mounted), 96'h3);
        chk("mount_protect", 96'(drv_protect), 96'h0);

        // Read on unmounted drive 2 is rejected
        drv_rd = 3'b100; cyc(); drv_rd = 3'b000;
        chk("unm_err", 96'(drv_err), 96'h4);
        chk("unm_busy", 96'(drv_busy), 96'h0);
        cyc();
        chk("unm_err_gone", 96'(drv_err), 96'h0);
        chk("unm_no_rd", 96'(sd_rd), 96'h0);

        // Read drive 1, LBA 0x12
        drv_lba[63:32] = 32'h12;
        drv_rd = 3'b010; cyc(); drv_rd = 3'b000;
        chk("rd1_busy", 96'(drv_busy), 96'h2);
        chk("rd1_wait", 96'(cpu_wait), 96'h1);
        chk("rd1_rd_not_yet", 96'(sd_rd), 96'h0);
        cyc();
        chk("rd1_sd_rd", 96'(sd_rd), 96'h2);
        chk("rd1_sd_lba", sd_lba, {32'h0, 32'h12, 32'h0});
        repeat (2) cyc();
        chk("rd1_rd_held", 96'(sd_rd), 96'h2);
        sd_ack = 3'b010; cyc();
        chk("rd1_rd_at_ack", 96'(sd_rd), 96'h2);
        sd_buff_wr = 1'b1; #1;
        chk("rd1_buff_we", 96'(drv_buff_we), 96'h2);
        sd_buff_wr = 1'b0;
        cyc();
        chk("rd1_rd_low", 96'(sd_rd), 96'h0);
        chk("rd1_busy_xfer", 96'(drv_busy), 96'h2);
        repeat (2) cyc();
        sd_ack = 3'b000; cyc();
        chk("rd1_no_done_yet", 96'(drv_done), 96'h0);
        cyc();
        chk("rd1_done", 96'(drv_done), 96'h2);
        chk("rd1_busy_clr", 96'(drv_busy), 96'h0);
        chk("rd1_wait_clr", 96'(cpu_wait), 96'h0);
        cyc();
        chk("rd1_done_pulse", 96'(drv_done), 96'h0);

        // Mount drive 2 (nonzero) and drive 1 read-only
        img_size = 64'd409600; img_readonly = 1'b0;
        img_mounted = 3'b100; cyc();
        img_readonly = 1'b1;
        img_mounted = 3'b010; cyc();
        img_mounted = 3'b000; img_readonly = 1'b0;
        chk("remount_state", 96'(drv_mounted), 96'h7);
        chk("remount_protect", 96'(drv_protect), 96'h2);

        // Write to read-only drive 1 is rejected
        drv_wr = 3'b010; cyc(); drv_wr = 3'b000;
        chk("ro_err", 96'(drv_err), 96'h2);
        chk("ro_busy", 96'(drv_busy), 96'h0);
        cyc();
        chk("ro_no_wr", 96'(sd_wr), 96'h0);
        chk("ro_err_gone", 96'(drv_err), 96'h0);

        // Reset puts last_grant at 2; mount state is kept
        reset = 1'b1; cyc(); reset = 1'b0; cyc();
        chk("rst_keep_mount", 96'(drv_mounted), 96'h7);

        // Simultaneous reads on 0 and 2: drive 0 first
        drv_lba = {32'hC2, 32'h0, 32'hA0};
        drv_rd = 3'b101; cyc(); drv_rd = 3'b000;
        chk("rr_busy", 96'(drv_busy), 96'h5);
        cyc();
        chk("rr_first_rd", 96'(sd_rd), 96'h1);
        chk("rr_first_lba", sd_lba, {32'h0, 32'h0, 32'hA0});
        drv_lba[31:0] = 32'hFF;
        drv_rd = 3'b001; cyc(); drv_rd = 3'b000;
        sd_ack = 3'b100; repeat (2) cyc(); sd_ack = 3'b000; cyc();
        chk("rr_foreign_ack", 96'(sd_rd), 96'h1);
        sd_ack = 3'b001; repeat (2) cyc();
        chk("rr_first_rd_low", 96'(sd_rd), 96'h0);
        sd_ack = 3'b000; repeat (2) cyc();
        chk("rr_first_done", 96'(drv_done), 96'h1);
        chk("rr_busy_left", 96'(drv_busy), 96'h4);
        cyc();
        chk("rr_second_rd", 96'(sd_rd), 96'h4);
        chk("rr_second_lba", sd_lba, {32'hC2, 32'h0, 32'hA0});
        sd_ack = 3'b100; repeat (2) cyc();
        chk("rr_second_rd_low", 96'(sd_rd), 96'h0);
        sd_ack = 3'b000; repeat (2) cyc();
        chk("rr_second_done", 96'(drv_done), 96'h4);
        chk("rr_all_idle", 96'(drv_busy), 96'h0);
        repeat (2) cyc();
        chk("rr_drop_no_grant", 96'(sd_rd), 96'h0);

        // Timeout: read drive 1 with no ack
        drv_lba[63:32] = 32'h33;
        drv_rd = 3'b010; cyc(); drv_rd = 3'b000;
        cyc();
        chk("to_rd", 96'(sd_rd), 96'h2);
        repeat (99) cyc();
        chk("to_rd_99", 96'(sd_rd), 96'h2);
        chk("to_err_99", 96'(drv_err), 96'h0);
        cyc();
        chk("to_rd_low", 96'(sd_rd), 96'h0);
        chk("to_err", 96'(drv_err), 96'h2);
        chk("to_busy", 96'(drv_busy), 96'h0);
        cyc();
        chk("to_err_gone", 96'(drv_err), 96'h0);

        // Normal read after timeout, then reset during XFER
        drv_lba[31:0] = 32'h44;
        drv_rd = 3'b001; cyc(); drv_rd = 3'b000;
        cyc();
        chk("post_to_rd", 96'(sd_rd), 96'h1);
        chk("post_to_lba", sd_lba, {32'hC2, 32'h33, 32'h44});
        sd_ack = 3'b001; repeat (2) cyc();
        chk("post_to_xfer", 96'(sd_rd), 96'h0);
        sd_ack = 3'b000; reset = 1'b1; cyc(); reset = 1'b0;
        chk("mid_rst_busy", 96'(drv_busy), 96'h0);
        chk("mid_rst_rdwr", 96'({sd_rd, sd_wr}), 96'h0);
        chk("mid_rst_lba", sd_lba, 96'h0);
        chk("mid_rst_pulses", 96'({drv_done, drv_err, cpu_wait}), 96'h0);
        chk("mid_rst_mount", 96'(drv_mounted), 96'h7);
        repeat (2) cyc();
        chk("mid_rst_no_done", 96'(drv_done), 96'h0);

        // Read+write same cycle on drive 0: write wins and completes
        drv_lba[31:0] = 32'h55;
        drv_rd = 3'b001; drv_wr = 3'b001; cyc(); drv_rd = 3'b000; drv_wr = 3'b000;
        cyc();
        chk("wr_sd_wr", 96'(sd_wr), 96'h1);
        chk("wr_sd_rd", 96'(sd_rd), 96'h0);
        chk("wr_lba", sd_lba, {32'h0, 32'h0, 32'h55});
        sd_ack = 3'b001; repeat (2) cyc();
        chk("wr_wr_low", 96'(sd_wr), 96'h0);
        sd_ack = 3'b000; repeat (2) cyc();
        chk("wr_done", 96'(drv_done), 96'h1);
        chk("wr_wait_clr", 96'(cpu_wait), 96'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
